// File: rtl/kill_dispatch_pkg.sv
// Shared definitions for the kill-search dispatcher.
//   - Board geometry: 15 x 15 cells, cell index = row*15 + col.
//   - Cell codes: EMPTY / BLACK / WHITE, 2 bits per cell.
//   - board_t: packed snapshot of all 225 cells handed to the search chain.
//   - state_e: dispatcher control states.
package kill_dispatch_pkg;

    localparam int BOARD_DIM   = 15;
    localparam int BOARD_CELLS = BOARD_DIM * BOARD_DIM;

    // Highest legal cell index and the stone-count ceiling.
    localparam logic [7:0] POS_MAX = 8'(BOARD_CELLS - 1);
    localparam logic [7:0] CNT_MAX = 8'(BOARD_CELLS);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BLACK = 2'd1,
        WHITE = 2'd2
    } cell_e;

    // Element i holds the 2-bit code of cell i.
    typedef logic [BOARD_CELLS-1:0][1:0] board_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/kill_dispatch.sv
// kill_dispatch: holds the game board, accepts moves while idle, and launches
// a kill search on an external chain, returning its verdict via a handshake.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_clear             empty the board (honoured in IDLE only)
//   i_move_valid/pos/color, o_move_ready   move offer and acceptance
//   o_move_err          one-cycle pulse after an accepted but illegal move
//   o_stone_cnt         stones on the board
//   i_query             start a search on the current board
//   o_board, o_depth    board snapshot and depth for the chain
//   o_start             one-cycle launch pulse
//   i_finish, i_sha     chain done / kill found
//   o_valid, i_ready    result handshake
//   o_sha, o_timeout    verdict: kill found / search abandoned
module kill_dispatch
    import kill_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int SEARCH_DEPTH   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_move_valid,
    input  logic [7:0] i_move_pos,
    input  logic [1:0] i_move_color,
    output logic       o_move_ready,
    output logic       o_move_err,
    output logic [7:0] o_stone_cnt,
    input  logic       i_query,
    output board_t     o_board,
    output logic [4:0] o_depth,
    output logic       o_start,
    input  logic       i_finish,
    input  logic       i_sha,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_sha,
    output logic       o_timeout
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    board_t           board_q;
    logic [7:0]       stone_cnt_q;
    logic             err_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             sha_q, timeout_q;

    logic move_acc, pos_ok, cell_free, move_ok, clear_go, timed_out, wait_end;

    assign move_acc  = i_move_valid & o_move_ready;
    assign pos_ok    = (i_move_pos <= POS_MAX);
    // Only look up the cell when the index is on the board.
    assign cell_free = pos_ok && (board_q[i_move_pos] == EMPTY);
    assign move_ok   = move_acc & cell_free & (i_move_color != EMPTY);
    assign clear_go  = (state_q == IDLE) & i_clear;
    assign timed_out = (wait_cnt_q == CNT_LAST);
    assign wait_end  = (state_q == WAIT) & (i_finish | timed_out);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // i_finish is only looked at in WAIT, so a level left over from the
    // previous run is harmless during LAUNCH.
    always_comb begin
        state_d      = state_q;
        o_move_ready = 1'b0;
        o_start      = 1'b0;
        o_valid      = 1'b0;
        case (state_q)
            IDLE: begin
                o_move_ready = ~i_clear;
                if (i_query) state_d = LAUNCH;
            end
            LAUNCH: begin
                o_start = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (i_finish | timed_out) state_d = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear beats a simultaneous move (o_move_ready is low while clearing).
    // The board can only change in IDLE, so it is stable for the whole search.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            board_q     <= '0;
            stone_cnt_q <= '0;
        end else if (clear_go) begin
            board_q     <= '0;
            stone_cnt_q <= '0;
        end else if (move_ok) begin
            board_q[i_move_pos] <= i_move_color;
            if (stone_cnt_q != CNT_MAX) stone_cnt_q <= stone_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) err_q <= 1'b0;
        else       err_q <= move_acc & ~move_ok;
    end

    // Counter is zero on WAIT entry and counts WAIT cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                  wait_cnt_q <= '0;
        else if (state_q == WAIT)   wait_cnt_q <= wait_cnt_q + 1'b1;
        else                        wait_cnt_q <= '0;
    end

    // Finish wins over a coincident timeout.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sha_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if (wait_end) begin
            sha_q     <= i_finish & i_sha;
            timeout_q <= ~i_finish;
        end
    end

    assign o_board     = board_q;
    assign o_depth     = 5'(SEARCH_DEPTH);
    assign o_stone_cnt = stone_cnt_q;
    assign o_move_err  = err_q;
    assign o_sha       = sha_q;
    assign o_timeout   = timeout_q;

endmodule
